// File: rtl/twi_status_pkg.sv
// Shared types for the TWI master status path: event flag bundle and status codes.
package twi_status_pkg;

   localparam int unsigned TWS_WIDTH = 5;

   typedef enum logic [TWS_WIDTH-1:0] {
      ST_START     = 5'h01,
      ST_RESTART   = 5'h02,
      ST_SLAW_ACK  = 5'h03,
      ST_SLAW_NACK = 5'h04,
      ST_DTX_ACK   = 5'h05,
      ST_DTX_NACK  = 5'h06,
      ST_ARB_LOST  = 5'h07,
      ST_SLAR_ACK  = 5'h08,
      ST_SLAR_NACK = 5'h09,
      ST_DRX_ACK   = 5'h0A,
      ST_DRX_NACK  = 5'h0B,
      ST_STOP      = 5'h0C,
      ST_BUS_ERR   = 5'h0D,
      ST_IDLE      = 5'h1F
   } status_code_t;

   // write = 1 means read direction (SLA+R / data received), matching the controller.
   typedef struct packed {
      logic bus_err;
      logic arb_lost;
      logic start;
      logic restart;
      logic stop;
      logic sla;
      logic write;
      logic nack;
   } twi_evt_t;

endpackage

// File: rtl/twi_status_encoder.sv
// Priority encoder from a completed bus event to its status code.
module twi_status_encoder
   import twi_status_pkg::*;
(
   input  twi_evt_t     evt,
   output status_code_t code_c
);

   always_comb begin
      code_c = ST_IDLE;
      if (evt.bus_err)       code_c = ST_BUS_ERR;
      else if (evt.arb_lost) code_c = ST_ARB_LOST;
      else if (evt.start)    code_c = ST_START;
      else if (evt.restart)  code_c = ST_RESTART;
      else if (evt.stop)     code_c = ST_STOP;
      else if (evt.sla) begin
         if (evt.write) code_c = evt.nack ? ST_SLAR_NACK : ST_SLAR_ACK;
         else           code_c = evt.nack ? ST_SLAW_NACK : ST_SLAW_ACK;
      end else begin
         if (evt.write) code_c = evt.nack ? ST_DRX_NACK : ST_DRX_ACK;
         else           code_c = evt.nack ? ST_DTX_NACK : ST_DTX_ACK;
      end
   end

endmodule

// File: rtl/twi_status_queue.sv
// Buffered TWI status path: encodes bus events, queues them, and presents the head code
// with interrupt, level and sticky overflow indications.
module twi_status_queue #(
   parameter int unsigned          TWS_WIDTH = twi_status_pkg::TWS_WIDTH,
   parameter int unsigned          DEPTH     = 4,
   parameter int unsigned          CNT_W     = $clog2(DEPTH) + 1,
   parameter logic [TWS_WIDTH-1:0] IDLE_CODE = TWS_WIDTH'('h1F)
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic                 evt_valid,
   input  logic                 evt_start,
   input  logic                 evt_restart,
   input  logic                 evt_sla,
   input  logic                 evt_write,
   input  logic                 evt_nack,
   input  logic                 evt_arb_lost,
   input  logic                 evt_stop,
   input  logic                 evt_bus_err,
   input  logic                 irq_en,
   input  logic                 status_ack,
   input  logic                 flush,
   input  logic                 ovf_clr,
   output logic [TWS_WIDTH-1:0] status_code,
   output logic                 irq,
   output logic [CNT_W-1:0]     q_count,
   output logic                 q_full,
   output logic                 overflow
);
   import twi_status_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);

   twi_evt_t             evt;
   status_code_t         enc_code_c;
   logic [TWS_WIDTH-1:0] code_c;

   logic [TWS_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;

   logic                 empty_c, full_c, push_c, pop_c, drop_c;
   logic [PTR_W-1:0]     wr_ptr_nxt, rd_ptr_nxt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic [TWS_WIDTH-1:0] head_nxt;

   assign evt = '{bus_err: evt_bus_err, arb_lost: evt_arb_lost, start: evt_start,
                  restart: evt_restart, stop: evt_stop, sla: evt_sla,
                  write: evt_write, nack: evt_nack};

   twi_status_encoder u_encoder (
      .evt    (evt),
      .code_c (enc_code_c)
   );

   assign code_c = TWS_WIDTH'(enc_code_c);

   // Next-state queue bookkeeping; flush cancels any concurrent push or pop.
   always_comb begin
      empty_c    = (q_count == '0);
      full_c     = (q_count == CNT_W'(DEPTH));
      pop_c      = status_ack & ~empty_c & ~flush;
      push_c     = evt_valid & (~full_c | pop_c) & ~flush;
      drop_c     = evt_valid & full_c & ~pop_c & ~flush;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      cnt_nxt    = q_count;
      if (flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         cnt_nxt    = '0;
      end else begin
         if (push_c) wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
         cnt_nxt = q_count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
      // Bypass the incoming code when it lands in the slot that becomes the head.
      head_nxt = (push_c && (wr_ptr == rd_ptr_nxt)) ? code_c : mem[rd_ptr_nxt];
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge pclk) begin
      if (push_c) mem[wr_ptr] <= code_c;
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         q_count     <= '0;
         q_full      <= 1'b0;
         overflow    <= 1'b0;
         irq         <= 1'b0;
         status_code <= IDLE_CODE;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         q_count     <= cnt_nxt;
         q_full      <= (cnt_nxt == CNT_W'(DEPTH));
         irq         <= irq_en & (cnt_nxt != '0);
         status_code <= (cnt_nxt == '0) ? IDLE_CODE : head_nxt;
         if (drop_c)       overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_twi_status_queue.sv
// Directed and randomized checks of twi_status_queue against a queue-based reference model.
module tb_twi_status_queue;

   localparam int unsigned DEPTH = 4;

   // Flag vector layout used by the stimulus tasks.
   localparam int B_START = 0, B_RESTART = 1, B_SLA = 2, B_WRITE = 3,
                  B_NACK = 4, B_ARB = 5, B_STOP = 6, B_BERR = 7;

   logic       pclk = 1'b0;
   logic       presetn, evt_valid, evt_start, evt_restart, evt_sla, evt_write, evt_nack;
   logic       evt_arb_lost, evt_stop, evt_bus_err, irq_en, status_ack, flush, ovf_clr;
   logic [4:0] status_code;
   logic       irq, q_full, overflow;
   logic [2:0] q_count;

   int errors = 0;
   int checks = 0;

   logic [4:0] mq[$];
   bit         m_ovf = 1'b0;
   bit         m_irq = 1'b0;

   always #5 pclk = ~pclk;

   twi_status_queue #(.DEPTH(DEPTH)) dut (
      .pclk(pclk), .presetn(presetn), .evt_valid(evt_valid), .evt_start(evt_start),
      .evt_restart(evt_restart), .evt_sla(evt_sla), .evt_write(evt_write),
      .evt_nack(evt_nack), .evt_arb_lost(evt_arb_lost), .evt_stop(evt_stop),
      .evt_bus_err(evt_bus_err), .irq_en(irq_en), .status_ack(status_ack),
      .flush(flush), .ovf_clr(ovf_clr), .status_code(status_code), .irq(irq),
      .q_count(q_count), .q_full(q_full), .overflow(overflow)
   );

   function automatic logic [4:0] encode(input logic [7:0] f);
      if (f[B_BERR])    return 5'h0D;
      if (f[B_ARB])     return 5'h07;
      if (f[B_START])   return 5'h01;
      if (f[B_RESTART]) return 5'h02;
      if (f[B_STOP])    return 5'h0C;
      if (f[B_SLA])     return f[B_WRITE] ? (f[B_NACK] ? 5'h09 : 5'h08)
                                          : (f[B_NACK] ? 5'h04 : 5'h03);
      return f[B_WRITE] ? (f[B_NACK] ? 5'h0B : 5'h0A) : (f[B_NACK] ? 5'h06 : 5'h05);
   endfunction

   function automatic logic [4:0] exp_code();
      return (mq.size() != 0) ? mq[0] : 5'h1F;
   endfunction

   task automatic set_flags(input logic [7:0] f);
      {evt_bus_err, evt_stop, evt_arb_lost, evt_nack, evt_write, evt_sla, evt_restart, evt_start} = f;
   endtask

   task automatic event_in(input logic [7:0] f);
      set_flags(f);
      evt_valid = 1'b1;
   endtask

   // One clock: the model consumes the inputs seen at the edge, then pulses are dropped.
   task automatic cycle();
      logic [7:0] f;
      bit pop;
      @(posedge pclk);
      f = {evt_bus_err, evt_stop, evt_arb_lost, evt_nack, evt_write, evt_sla, evt_restart, evt_start};
      if (!presetn) begin
         mq.delete();
         m_ovf = 1'b0;
         m_irq = 1'b0;
      end else begin
         if (flush) begin
            mq.delete();
            if (ovf_clr) m_ovf = 1'b0;
         end else begin
            pop = status_ack && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (evt_valid && mq.size() < DEPTH) mq.push_back(encode(f));
            else if (evt_valid) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (evt_valid && mq.size() < DEPTH && !pop && ovf_clr) m_ovf = 1'b0;
            if (!evt_valid && ovf_clr) m_ovf = 1'b0;
            if (evt_valid && pop && ovf_clr) m_ovf = 1'b0;
         end
         m_irq = irq_en && (mq.size() != 0);
      end
      #1;
      evt_valid = 1'b0; status_ack = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
      set_flags(8'h00);
   endtask

   task automatic test_reset();
      presetn = 1'b0;
      cycle(); cycle();
      checks++; if (status_code !== 5'h1F) begin errors++; $display("FAIL reset_code got=%h exp=1f", status_code); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", q_count); end
      checks++; if (overflow !== 1'b0 || q_full !== 1'b0) begin errors++; $display("FAIL reset_flags ovf=%b full=%b exp=0,0", overflow, q_full); end
      presetn = 1'b1;
      cycle();
   endtask

   task automatic test_sequence();
      logic [4:0] exp_codes [3];
      exp_codes[0] = 5'h03; exp_codes[1] = 5'h06; exp_codes[2] = 5'h1F;
      irq_en = 1'b1;
      event_in(8'h01 << B_START); cycle();
      checks++; if (status_code !== 5'h01 || irq !== 1'b1) begin errors++; $display("FAIL seq_latency code=%h irq=%b exp=01,1", status_code, irq); end
      event_in(8'h01 << B_SLA); cycle();
      event_in(8'h01 << B_NACK); cycle();
      checks++; if (q_count !== 3'd3 || status_code !== 5'h01) begin errors++; $display("FAIL seq_fill count=%0d code=%h exp=3,01", q_count, status_code); end
      for (int i = 0; i < 3; i++) begin
         status_ack = 1'b1; cycle();
         checks++; if (status_code !== exp_codes[i]) begin errors++; $display("FAIL seq_pop%0d got=%h exp=%h", i, status_code, exp_codes[i]); end
      end
      checks++; if (irq !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL seq_drained irq=%b count=%0d exp=0,0", irq, q_count); end
   endtask

   task automatic test_priority();
      event_in((8'h01 << B_ARB) | (8'h01 << B_START)); cycle();
      checks++; if (status_code !== 5'h07) begin errors++; $display("FAIL prio_arb got=%h exp=07", status_code); end
      status_ack = 1'b1; cycle();
      event_in(8'hFF); cycle();
      checks++; if (status_code !== 5'h0D) begin errors++; $display("FAIL prio_berr got=%h exp=0d", status_code); end
      status_ack = 1'b1; cycle();
   endtask

   task automatic test_overflow();
      logic [7:0] ev [5];
      logic [4:0] exp_codes [4];
      ev[0] = 8'h01 << B_START;  ev[1] = 8'h01 << B_RESTART; ev[2] = 8'h01 << B_STOP;
      ev[3] = (8'h01 << B_SLA) | (8'h01 << B_WRITE);
      ev[4] = (8'h01 << B_WRITE) | (8'h01 << B_NACK);
      for (int i = 0; i < 5; i++) begin event_in(ev[i]); cycle(); end
      checks++; if (q_full !== 1'b1 || overflow !== 1'b1 || q_count !== 3'd4) begin errors++; $display("FAIL ovf_fill full=%b ovf=%b count=%0d exp=1,1,4", q_full, overflow, q_count); end
      event_in(8'h00); status_ack = 1'b1; cycle();
      checks++; if (q_count !== 3'd4 || overflow !== 1'b1 || status_code !== 5'h02) begin errors++; $display("FAIL ovf_pushpop count=%0d ovf=%b code=%h exp=4,1,02", q_count, overflow, status_code); end
      ovf_clr = 1'b1; cycle();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
      event_in(8'h01 << B_STOP); ovf_clr = 1'b1; cycle();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
      ovf_clr = 1'b1; cycle();
      exp_codes[0] = 5'h0C; exp_codes[1] = 5'h08; exp_codes[2] = 5'h05; exp_codes[3] = 5'h1F;
      for (int i = 0; i < 4; i++) begin
         status_ack = 1'b1; cycle();
         checks++; if (status_code !== exp_codes[i]) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, status_code, exp_codes[i]); end
      end
   endtask

   task automatic test_empty_ack();
      status_ack = 1'b1; cycle();
      checks++; if (q_count !== 3'd0 || status_code !== 5'h1F) begin errors++; $display("FAIL empty_ack count=%0d code=%h exp=0,1f", q_count, status_code); end
      event_in(8'h01 << B_RESTART); status_ack = 1'b1; cycle();
      checks++; if (q_count !== 3'd1 || status_code !== 5'h02) begin errors++; $display("FAIL empty_pushpop count=%0d code=%h exp=1,02", q_count, status_code); end
      status_ack = 1'b1; cycle();
   endtask

   task automatic test_flush_irq();
      for (int i = 0; i < 3; i++) begin event_in(8'h01 << B_START); cycle(); end
      flush = 1'b1; event_in(8'h01 << B_STOP); cycle();
      checks++; if (q_count !== 3'd0 || status_code !== 5'h1F || irq !== 1'b0) begin errors++; $display("FAIL flush count=%0d code=%h irq=%b exp=0,1f,0", q_count, status_code, irq); end
      event_in(8'h01 << B_SLA); cycle();
      event_in(8'h01 << B_STOP); cycle();
      irq_en = 1'b0; cycle();
      checks++; if (irq !== 1'b0 || q_count !== 3'd2) begin errors++; $display("FAIL irq_off irq=%b count=%0d exp=0,2", irq, q_count); end
      irq_en = 1'b1; cycle();
      checks++; if (irq !== 1'b1 || status_code !== 5'h03) begin errors++; $display("FAIL irq_on irq=%b code=%h exp=1,03", irq, status_code); end
      presetn = 1'b0; cycle();
      checks++; if (q_count !== 3'd0 || status_code !== 5'h1F) begin errors++; $display("FAIL mid_reset count=%0d code=%h exp=0,1f", q_count, status_code); end
      presetn = 1'b1; cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(99) < 55) event_in(8'($urandom()));
         status_ack = ($urandom_range(99) < 40);
         flush      = ($urandom_range(99) < 4);
         ovf_clr    = ($urandom_range(99) < 10);
         irq_en     = ($urandom_range(99) < 90);
         presetn    = ($urandom_range(199) != 0);
         cycle();
         checks++;
         if (status_code !== exp_code() || q_count !== 3'(mq.size()) || irq !== m_irq ||
             q_full !== (mq.size() == DEPTH) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand%0d code=%h/%h count=%0d/%0d irq=%b/%b full=%b ovf=%b/%b",
                     n, status_code, exp_code(), q_count, mq.size(), irq, m_irq, q_full, overflow, m_ovf);
         end
      end
   endtask

   initial begin
      presetn = 1'b0; evt_valid = 1'b0; irq_en = 1'b0; status_ack = 1'b0;
      flush = 1'b0; ovf_clr = 1'b0;
      set_flags(8'h00);
      test_reset();
      test_sequence();
      test_priority();
      test_overflow();
      test_empty_ack();
      test_flush_irq();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/twi_status_queue.md
Name: twi_status_queue

Overview:
- Registered, buffered status path for the APB TWI master.
- Encodes each controller bus event (start, repeated start, SLA+R/W, data byte, ACK/NACK, arbitration loss, stop, bus error) into a TWS_WIDTH status code.
- Queues codes in a DEPTH-entry FIFO so back-to-back events are not lost while software services the interrupt.
- Drives the head-of-queue code to the status register, plus interrupt, level and overflow indications.

Parameters:
- TWS_WIDTH, 5, status code width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy count width.
- IDLE_CODE, 5'h1F, code presented when queue empty ("no relevant state").

Ports:
- pclk  in  1  system/APB clock; all state on rising edge.
- presetn  in  1  synchronous active-low reset.
- evt_valid  in  1  one-cycle pulse: an event completed this cycle.
- evt_start  in  1  start condition completed.
- evt_restart  in  1  repeated start completed.
- evt_sla  in  1  byte just transferred was SLA+R/W.
- evt_write  in  1  read direction (1 = SLA+R / data received); same encoding as controller.
- evt_nack  in  1  acknowledge bit sampled high.
- evt_arb_lost  in  1  arbitration lost.
- evt_stop  in  1  stop condition completed.
- evt_bus_err  in  1  illegal start/stop detected.
- irq_en  in  1  interrupt enable from control register.
- status_ack  in  1  one-cycle pulse: software consumed head code (TWINT write-1).
- flush  in  1  discard all queued codes.
- ovf_clr  in  1  clear sticky overflow.
- status_code  out  TWS_WIDTH  head code, or IDLE_CODE when empty.
- irq  out  1  registered: irq_en & ~empty.
- q_count  out  CNT_W  current occupancy, 0..DEPTH.
- q_full  out  1  q_count == DEPTH.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Clock pclk; reset synchronous, active-low on presetn, sampled only at the pclk edge.
- Reset values:
  - status_code = IDLE_CODE
  - irq = 0, q_count = 0, q_full = 0, overflow = 0
  - read/write pointers = 0
- Encoding, combinational, priority high to low:
  - bus_err -> 5'h0D
  - arb_lost -> 5'h07
  - start -> 5'h01
  - restart -> 5'h02
  - stop -> 5'h0C
  - SLA+W ACK/NACK -> 5'h03/5'h04
  - SLA+R ACK/NACK -> 5'h08/5'h09
  - data tx ACK/NACK -> 5'h05/5'h06
  - data rx ACK/NACK -> 5'h0A/5'h0B
  - Lower-priority flags are ignored when a higher one is set.
- Push: evt_valid=1 writes the encoded code at wr_ptr and increments it.
- Pop: status_ack=1 with queue non-empty increments rd_ptr. status_ack on an empty queue is ignored (no underflow, count stays 0).
- Latency: event at edge N into an empty queue -> status_code and irq valid after edge N+1 (one register stage, no combinational input-to-output path).
- status_code and irq are registered from the next-state FIFO head and level.
- Simultaneous push and pop:
  - Non-empty queue: both occur, count unchanged.
  - Empty queue: pop ignored, push occurs.
  - Full queue: both occur, no overflow.
- Push when full without pop: code dropped, FIFO unchanged, overflow set.
- overflow stays set until ovf_clr=1 or reset. If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).
- flush=1: pointers and count to 0 next edge; any concurrent push or pop is discarded; overflow unaffected.
- Pointers are (log2 DEPTH)-bit and wrap naturally. Full/empty are derived from q_count, not pointer compare.
- irq_en deasserted: irq=0 next edge; queue contents retained. Re-enabling raises irq next edge if non-empty.
- Reset mid-operation discards all entries; no partial pop.

Decomposition:
- Package twi_status_pkg holds:
  - typedef enum logic [TWS_WIDTH-1:0] status_code_t with all 13 codes plus IDLE.
  - Default TWS_WIDTH.
  - Packed struct twi_evt_t bundling the eight event flags.
- Sub-module twi_status_encoder: pure combinational twi_evt_t -> status_code_t priority encoder, instantiated once. FIFO storage, pointers, flags and output registers live in the top.

Test Plan:
- Reset with presetn=0 for 2 cycles -> status_code=5'h1F, irq=0, q_count=0, overflow=0.
- irq_en=1; start, then SLA+W ACK, then data tx NACK on consecutive cycles -> q_count=3, status_code=5'h01; status_ack thrice -> 5'h03, 5'h06, then 5'h1F, irq=0.
- evt_valid with arb_lost=1 and start=1 -> code 5'h07; bus_err=1 with all flags set -> 5'h0D.
- DEPTH=4: five events with no ack -> q_full=1, overflow=1, fifth code absent; push+ack on full -> no overflow change, count stays 4; ovf_clr -> overflow=0.
- Empty queue: status_ack alone -> count 0; push+ack same cycle -> count 1, code visible next cycle.
- Queue of 3 with flush and evt_valid same cycle -> count 0, status_code=5'h1F; irq_en=0 with non-empty queue -> irq=0, re-enable -> irq=1 next edge.
